sync_pkt_fifo: RTL and testbench

- Single-clock, parametrised FIFO for the Ethernet datapath.
- Builds on the dual-port buffer memory and adds pointer management, status flags, occupancy and a selectable read mode.
- Optional packet mode holds a frame invisible to the reader until its last beat is committed, and can discard a partial frame. This lets the MAC RX path drop bad-FCS or oversize frames before the UDP/IP layers see them.

---
 rtl/sync_pkt_fifo.sv | 204 ++++++++++++++++++++
 tb/tb_sync_pkt_fifo.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_pkt_fifo.sv
// Single-clock FIFO with optional packet commit/discard for the Ethernet datapath.
// Latency: a write becomes readable one cycle after it (or its frame's last beat) is accepted; FWFT=0 adds one read cycle.
// Backpressure: o_full rejects writes (o_overflow pulse); o_empty rejects reads (o_underflow pulse); all flags registered.
//
// Ports:
//   i_clk, i_reset_n                 clock, asynchronous active-low reset
//   i_wr_en/i_wr_data/i_wr_last      write beat with end-of-frame marker
//   i_wr_drop                        discard the frame currently being written
//   o_full, o_almost_full            write-side occupancy flags (include uncommitted words)
//   i_rd_en                          pop (FWFT=1) or read request (FWFT=0)
//   o_rd_data/o_rd_last/o_rd_valid   read beat
//   o_empty, o_almost_empty, o_count read-side (committed) occupancy
//   o_overflow, o_underflow          one-cycle rejected-access pulses

module sync_pkt_fifo #(
    parameter int DATA_WIDTH          = 8,
    parameter int FIFO_DEPTH          = 64,
    parameter int ADDR_BITS           = $clog2(FIFO_DEPTH),
    parameter int FWFT                = 1,
    parameter int PACKET_MODE         = 1,
    parameter int ALMOST_FULL_THRESH  = FIFO_DEPTH - 4,
    parameter int ALMOST_EMPTY_THRESH = 4
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_wr_en,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic                  i_wr_last,
    input  logic                  i_wr_drop,
    output logic                  o_full,
    output logic                  o_almost_full,
    input  logic                  i_rd_en,
    output logic [DATA_WIDTH-1:0] o_rd_data,
    output logic                  o_rd_last,
    output logic                  o_rd_valid,
    output logic                  o_empty,
    output logic                  o_almost_empty,
    output logic [ADDR_BITS:0]    o_count,
    output logic                  o_overflow,
    output logic                  o_underflow
);

    // Pointers carry one extra wrap bit so that full (difference == depth)
    // and empty (difference == 0) stay distinguishable across wrap-around.
    localparam int              PW      = ADDR_BITS + 1;
    localparam logic [PW-1:0]   DEPTH_P = PW'(FIFO_DEPTH);
    localparam logic [PW-1:0]   AF_P    = PW'(ALMOST_FULL_THRESH);
    localparam logic [PW-1:0]   AE_P    = PW'(ALMOST_EMPTY_THRESH);
    localparam logic [PW-1:0]   ONE     = PW'(1);

    // Storage: {last, data}. Not reset.
    logic [DATA_WIDTH:0] mem [FIFO_DEPTH];

    // Architectural state
    logic [PW-1:0] wr_ptr;      // next write slot (includes uncommitted beats)
    logic [PW-1:0] commit_ptr;  // end of the readable region
    logic [PW-1:0] rd_ptr;      // next read slot
    logic          bad_frame;   // current frame overflowed; swallow until its last beat

    // Registered flags
    logic          full_q;
    logic          afull_q;
    logic          empty_q;
    logic          aempty_q;
    logic [PW-1:0] count_q;
    logic          ovf_q;
    logic          udf_q;

    // Next-state
    logic [PW-1:0] wr_ptr_nxt;
    logic [PW-1:0] commit_pm_nxt;
    logic [PW-1:0] commit_ptr_nxt;
    logic [PW-1:0] rd_ptr_nxt;
    logic          bad_frame_nxt;
    logic [PW-1:0] wocc_nxt;
    logic [PW-1:0] count_nxt;

    logic          wr_acc;
    logic          wr_rej;
    logic          rd_acc;
    logic          rd_rej;

    // A drop in the same cycle silently discards the write (no overflow).
    assign wr_acc = i_wr_en && !full_q && !bad_frame && !i_wr_drop;
    assign wr_rej = i_wr_en && full_q && !i_wr_drop;
    assign rd_acc = i_rd_en && !empty_q;
    assign rd_rej = i_rd_en && empty_q;

    always_comb begin
        wr_ptr_nxt    = wr_ptr;
        commit_pm_nxt = commit_ptr;
        bad_frame_nxt = bad_frame;

        if (i_wr_drop) begin
            // Rewind to the last committed frame boundary; any pending
            // overflow state belongs to the frame being discarded.
            wr_ptr_nxt    = commit_ptr;
            bad_frame_nxt = 1'b0;
        end else if (bad_frame) begin
            // Overflowed frame: ignore every beat, rewind on its last beat.
            if (i_wr_en && i_wr_last) begin
                wr_ptr_nxt    = commit_ptr;
                bad_frame_nxt = 1'b0;
            end
        end else if (wr_rej) begin
            if (PACKET_MODE != 0) begin
                // A rejected last beat ends the frame right away; otherwise
                // remember to discard the remainder of the frame.
                if (i_wr_last) begin
                    wr_ptr_nxt = commit_ptr;
                end else begin
                    bad_frame_nxt = 1'b1;
                end
            end
        end else if (wr_acc) begin
            wr_ptr_nxt = wr_ptr + ONE;
            if (i_wr_last) begin
                commit_pm_nxt = wr_ptr + ONE;
            end
        end

        // Plain FIFO: every accepted word is immediately committed.
        commit_ptr_nxt = (PACKET_MODE != 0) ? commit_pm_nxt : wr_ptr_nxt;

        rd_ptr_nxt = rd_acc ? (rd_ptr + ONE) : rd_ptr;

        wocc_nxt  = wr_ptr_nxt - rd_ptr_nxt;
        count_nxt = commit_ptr_nxt - rd_ptr_nxt;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wr_ptr     <= '0;
            commit_ptr <= '0;
            rd_ptr     <= '0;
            bad_frame  <= 1'b0;
            full_q     <= 1'b0;
            afull_q    <= 1'b0;
            empty_q    <= 1'b1;
            aempty_q   <= 1'b1;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
        end else begin
            wr_ptr     <= wr_ptr_nxt;
            commit_ptr <= commit_ptr_nxt;
            rd_ptr     <= rd_ptr_nxt;
            bad_frame  <= bad_frame_nxt;
            full_q     <= (wocc_nxt == DEPTH_P);
            afull_q    <= (wocc_nxt >= AF_P);
            empty_q    <= (count_nxt == '0);
            aempty_q   <= (count_nxt <= AE_P);
            count_q    <= count_nxt;
            ovf_q      <= wr_rej;
            udf_q      <= rd_rej;
        end
    end

    always_ff @(posedge i_clk) begin
        if (wr_acc) begin
            mem[wr_ptr[ADDR_BITS-1:0]] <= {i_wr_last, i_wr_data};
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word shown directly; forced to zero while nothing is
            // readable so the outputs are defined out of reset.
            logic [DATA_WIDTH:0] head;
            assign head       = mem[rd_ptr[ADDR_BITS-1:0]];
            assign o_rd_data  = empty_q ? '0 : head[DATA_WIDTH-1:0];
            assign o_rd_last  = !empty_q && head[DATA_WIDTH];
            assign o_rd_valid = !empty_q;
        end else begin : g_reg
            // Registered read: data appears the cycle after the accepted
            // request and holds until the next one.
            logic [DATA_WIDTH:0] rd_word;
            logic                rd_vld;
            always_ff @(posedge i_clk or negedge i_reset_n) begin
                if (!i_reset_n) begin
                    rd_word <= '0;
                    rd_vld  <= 1'b0;
                end else begin
                    rd_vld <= rd_acc;
                    if (rd_acc) begin
                        rd_word <= mem[rd_ptr[ADDR_BITS-1:0]];
                    end
                end
            end
            assign o_rd_data  = rd_word[DATA_WIDTH-1:0];
            assign o_rd_last  = rd_word[DATA_WIDTH];
            assign o_rd_valid = rd_vld;
        end
    endgenerate

    assign o_full         = full_q;
    assign o_almost_full  = afull_q;
    assign o_empty        = empty_q;
    assign o_almost_empty = aempty_q;
    assign o_count        = count_q;
    assign o_overflow     = ovf_q;
    assign o_underflow    = udf_q;

endmodule

// File: tb/tb_sync_pkt_fifo.sv
// Bench for sync_pkt_fifo: instance a is FWFT packet mode, instance b is a registered-read plain FIFO.
// Table-driven vectors for frame commit/drop, scoreboard queues for long streams and full/empty corners.
// Inputs driven 1 time unit after the rising edge; outputs sampled at the same point.

module tb_sync_pkt_fifo;

    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    // Instance a: FWFT=1, PACKET_MODE=1
    logic       a_we = 1'b0, a_wl = 1'b0, a_drop = 1'b0, a_re = 1'b0;
    logic [7:0] a_wd = 8'h00;
    logic       a_full, a_af, a_rlast, a_rvld, a_empty, a_ae, a_ovf, a_udf;
    logic [7:0] a_rdata;
    logic [6:0] a_count;

    // Instance b: FWFT=0, PACKET_MODE=0
    logic       b_we = 1'b0, b_wl = 1'b0, b_drop = 1'b0, b_re = 1'b0;
    logic [7:0] b_wd = 8'h00;
    logic       b_full, b_af, b_rlast, b_rvld, b_empty, b_ae, b_ovf, b_udf;
    logic [7:0] b_rdata;
    logic [6:0] b_count;

    sync_pkt_fifo #(.DATA_WIDTH(8), .FIFO_DEPTH(64), .FWFT(1), .PACKET_MODE(1)) dut_a (
        .i_clk(clk), .i_reset_n(rst_n),
        .i_wr_en(a_we), .i_wr_data(a_wd), .i_wr_last(a_wl), .i_wr_drop(a_drop),
        .o_full(a_full), .o_almost_full(a_af),
        .i_rd_en(a_re), .o_rd_data(a_rdata), .o_rd_last(a_rlast), .o_rd_valid(a_rvld),
        .o_empty(a_empty), .o_almost_empty(a_ae), .o_count(a_count),
        .o_overflow(a_ovf), .o_underflow(a_udf)
    );

    sync_pkt_fifo #(.DATA_WIDTH(8), .FIFO_DEPTH(64), .FWFT(0), .PACKET_MODE(0)) dut_b (
        .i_clk(clk), .i_reset_n(rst_n),
        .i_wr_en(b_we), .i_wr_data(b_wd), .i_wr_last(b_wl), .i_wr_drop(b_drop),
        .o_full(b_full), .o_almost_full(b_af),
        .i_rd_en(b_re), .o_rd_data(b_rdata), .o_rd_last(b_rlast), .o_rd_valid(b_rvld),
        .o_empty(b_empty), .o_almost_empty(b_ae), .o_count(b_count),
        .o_overflow(b_ovf), .o_underflow(b_udf)
    );

    int tests = 0;
    int fails = 0;

    logic [8:0] qa[$];
    logic [8:0] qb[$];

    typedef struct {
        logic       we;
        logic [7:0] wd;
        logic       wl;
        logic       drop;
        logic       re;
        logic       e_empty;
        logic [6:0] e_count;
        logic [7:0] e_data;
        logic       e_last;
        logic       e_ovf;
        logic       e_udf;
    } vec_t;

    function automatic vec_t mk(input logic we, input logic [7:0] wd, input logic wl,
                                input logic drop, input logic re, input logic e_empty,
                                input logic [6:0] e_count, input logic [7:0] e_data,
                                input logic e_last, input logic e_ovf, input logic e_udf);
        vec_t v;
        v.we = we; v.wd = wd; v.wl = wl; v.drop = drop; v.re = re;
        v.e_empty = e_empty; v.e_count = e_count; v.e_data = e_data;
        v.e_last = e_last; v.e_ovf = e_ovf; v.e_udf = e_udf;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Pop one word from instance a, checking the FWFT head against the scoreboard first.
    task automatic pop_a(input string name);
        logic [8:0] e;
        if (qa.size() == 0) begin
            chk({name, " sb_empty"}, 32'(qa.size()), 32'(1));
        end else begin
            e = qa.pop_front();
            chk({name, " vld"},  32'(a_rvld),  32'(1));
            chk({name, " data"}, 32'(a_rdata), 32'(e[7:0]));
            chk({name, " last"}, 32'(a_rlast), 32'(e[8]));
        end
        a_re = H;
        tick();
        a_re = L;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       tv[$];
        int         ovf_cnt;
        int         m;
        logic [7:0] nv;
        logic [7:0] last_rd;
        logic [8:0] e;
        logic       wacc, racc, we_c, re_c;

        // ---------------- vectors: 3-beat frame, underflow, drop ----------------
        tv.push_back(mk(H, 8'hA1, L, L, L,  H, 7'd0, 8'h00, L, L, L));
        tv.push_back(mk(H, 8'hA2, L, L, L,  H, 7'd0, 8'h00, L, L, L));
        tv.push_back(mk(H, 8'hA3, H, L, L,  L, 7'd3, 8'hA1, L, L, L));
        tv.push_back(mk(L, 8'h00, L, L, H,  L, 7'd2, 8'hA2, L, L, L));
        tv.push_back(mk(L, 8'h00, L, L, H,  L, 7'd1, 8'hA3, H, L, L));
        tv.push_back(mk(L, 8'h00, L, L, H,  H, 7'd0, 8'h00, L, L, L));
        tv.push_back(mk(L, 8'h00, L, L, H,  H, 7'd0, 8'h00, L, L, H));
        tv.push_back(mk(L, 8'h00, L, L, L,  H, 7'd0, 8'h00, L, L, L));
        for (int i = 0; i < 5; i++)
            tv.push_back(mk(H, 8'(8'h50 + i), L, L, L,  H, 7'd0, 8'h00, L, L, L));
        tv.push_back(mk(H, 8'h99, L, H, L,  H, 7'd0, 8'h00, L, L, L));
        tv.push_back(mk(H, 8'h11, L, L, L,  H, 7'd0, 8'h00, L, L, L));
        tv.push_back(mk(H, 8'h22, H, L, L,  L, 7'd2, 8'h11, L, L, L));
        tv.push_back(mk(L, 8'h00, L, L, H,  L, 7'd1, 8'h22, H, L, L));
        tv.push_back(mk(L, 8'h00, L, L, H,  H, 7'd0, 8'h00, L, L, L));

        // ---------------- reset ----------------
        #2 rst_n = 1'b0;
        tick();
        tick();
        chk("rst a_empty",  32'(a_empty), 32'(1));
        chk("rst a_aempty", 32'(a_ae),    32'(1));
        chk("rst a_full",   32'(a_full),  32'(0));
        chk("rst a_afull",  32'(a_af),    32'(0));
        chk("rst a_count",  32'(a_count), 32'(0));
        chk("rst a_valid",  32'(a_rvld),  32'(0));
        chk("rst a_data",   32'(a_rdata), 32'(0));
        chk("rst a_last",   32'(a_rlast), 32'(0));
        chk("rst a_ovf",    32'(a_ovf),   32'(0));
        chk("rst a_udf",    32'(a_udf),   32'(0));
        chk("rst b_empty",  32'(b_empty), 32'(1));
        chk("rst b_aempty", 32'(b_ae),    32'(1));
        chk("rst b_full",   32'(b_full),  32'(0));
        chk("rst b_afull",  32'(b_af),    32'(0));
        chk("rst b_valid",  32'(b_rvld),  32'(0));
        chk("rst b_data",   32'(b_rdata), 32'(0));
        chk("rst b_last",   32'(b_rlast), 32'(0));
        chk("rst b_ovf",    32'(b_ovf),   32'(0));
        chk("rst b_udf",    32'(b_udf),   32'(0));
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < tv.size(); i++) begin
            a_we = tv[i].we; a_wd = tv[i].wd; a_wl = tv[i].wl;
            a_drop = tv[i].drop; a_re = tv[i].re;
            tick();
            chk($sformatf("v%0d empty", i), 32'(a_empty), 32'(tv[i].e_empty));
            chk($sformatf("v%0d count", i), 32'(a_count), 32'(tv[i].e_count));
            chk($sformatf("v%0d valid", i), 32'(a_rvld),  32'(!tv[i].e_empty));
            chk($sformatf("v%0d data", i),  32'(a_rdata), 32'(tv[i].e_data));
            chk($sformatf("v%0d last", i),  32'(a_rlast), 32'(tv[i].e_last));
            chk($sformatf("v%0d ovf", i),   32'(a_ovf),   32'(tv[i].e_ovf));
            chk($sformatf("v%0d udf", i),   32'(a_udf),   32'(tv[i].e_udf));
        end
        a_we = L; a_wl = L; a_drop = L; a_re = L;

        // ---------------- oversize frame: auto-drop ----------------
        ovf_cnt = 0;
        for (int i = 1; i <= 70; i++) begin
            a_we = H; a_wd = 8'(i); a_wl = (i == 70);
            tick();
            ovf_cnt += int'(a_ovf);
            if (i == 59) chk("big afull@59", 32'(a_af), 32'(0));
            if (i == 60) chk("big afull@60", 32'(a_af), 32'(1));
            if (i == 63) chk("big full@63",  32'(a_full), 32'(0));
            if (i == 64) begin
                chk("big full@64",  32'(a_full),  32'(1));
                chk("big count@64", 32'(a_count), 32'(0));
                chk("big empty@64", 32'(a_empty), 32'(1));
            end
        end
        a_we = L; a_wl = L;
        chk("big ovf pulses", 32'(ovf_cnt), 32'(6));
        chk("big empty end",  32'(a_empty), 32'(1));
        chk("big full end",   32'(a_full),  32'(0));
        chk("big count end",  32'(a_count), 32'(0));
        tick();
        chk("big ovf idle",   32'(a_ovf),   32'(0));
        chk("big afull idle", 32'(a_af),    32'(0));
        // next frame is accepted normally
        a_we = H; a_wd = 8'hC1; a_wl = L; tick(); qa.push_back({1'b0, 8'hC1});
        a_wd = 8'hC2; a_wl = H;           tick(); qa.push_back({1'b1, 8'hC2});
        a_we = L; a_wl = L;
        chk("post-drop count", 32'(a_count), 32'(2));
        pop_a("post-drop 0");
        pop_a("post-drop 1");
        chk("post-drop empty", 32'(a_empty), 32'(1));

        // ---------------- count 63: simultaneous r/w, full, overflow ----------------
        for (int i = 0; i < 63; i++) begin
            a_we = H; a_wd = 8'(i); a_wl = (i == 62);
            tick();
            qa.push_back({(i == 62), 8'(i)});
        end
        a_we = L; a_wl = L;
        chk("c63 count", 32'(a_count), 32'(63));
        chk("c63 afull", 32'(a_af),    32'(1));
        chk("c63 full",  32'(a_full),  32'(0));
        e = qa.pop_front();
        chk("c63 head", 32'(a_rdata), 32'(e[7:0]));
        a_we = H; a_wd = 8'h70; a_wl = H; a_re = H;
        tick();
        qa.push_back({1'b1, 8'h70});
        a_re = L;
        chk("c63 rw count", 32'(a_count), 32'(63));
        chk("c63 rw full",  32'(a_full),  32'(0));
        a_wd = 8'h71; a_wl = H;
        tick();
        qa.push_back({1'b1, 8'h71});
        chk("c64 full",   32'(a_full),  32'(1));
        chk("c64 afull",  32'(a_af),    32'(1));
        chk("c64 count",  32'(a_count), 32'(64));
        chk("c64 aempty", 32'(a_ae),    32'(0));
        a_wd = 8'hEE; a_wl = L;
        tick();
        chk("c64 ovf1", 32'(a_ovf), 32'(1));
        a_wd = 8'hEF; a_wl = H;
        tick();
        chk("c64 ovf2", 32'(a_ovf), 32'(1));
        a_we = L; a_wl = L;
        tick();
        chk("c64 ovf idle",   32'(a_ovf),   32'(0));
        chk("c64 full idle",  32'(a_full),  32'(1));
        chk("c64 count idle", 32'(a_count), 32'(64));
        for (int i = 0; i < 64; i++) pop_a($sformatf("drain%0d", i));
        chk("drain empty",  32'(a_empty), 32'(1));
        chk("drain aempty", 32'(a_ae),    32'(1));
        chk("drain full",   32'(a_full),  32'(0));

        // ---------------- instance b: registered read, streaming across wrap ----------------
        m = 0;
        nv = 8'h00;
        for (int i = 0; i < 64; i++) begin
            b_we = H; b_wd = nv;
            tick();
            qb.push_back({1'b0, nv});
            nv++;
            m++;
            if (i == 0) begin
                chk("b first count", 32'(b_count), 32'(1));
                chk("b first empty", 32'(b_empty), 32'(0));
                chk("b first valid", 32'(b_rvld),  32'(0));
            end
        end
        b_we = L;
        chk("b fill full",  32'(b_full),  32'(1));
        chk("b fill afull", 32'(b_af),    32'(1));
        chk("b fill count", 32'(b_count), 32'(64));
        last_rd = 8'h00;
        for (int c = 0; c < 200; c++) begin
            we_c = H;
            re_c = (c % 9 != 8);
            wacc = we_c && (m != 64);
            racc = re_c && (m != 0);
            b_we = we_c; b_re = re_c; b_wd = nv;
            tick();
            if (racc) begin
                e = qb.pop_front();
                m--;
                last_rd = e[7:0];
                chk($sformatf("s%0d valid", c), 32'(b_rvld),  32'(1));
                chk($sformatf("s%0d data", c),  32'(b_rdata), 32'(e[7:0]));
                chk($sformatf("s%0d last", c),  32'(b_rlast), 32'(e[8]));
            end else begin
                chk($sformatf("s%0d valid", c), 32'(b_rvld), 32'(0));
            end
            if (wacc) begin
                qb.push_back({1'b0, nv});
                nv++;
                m++;
            end
            chk($sformatf("s%0d full", c),  32'(b_full),  32'(m == 64));
            chk($sformatf("s%0d empty", c), 32'(b_empty), 32'(m == 0));
            chk($sformatf("s%0d count", c), 32'(b_count), 32'(m));
            chk($sformatf("s%0d ovf", c),   32'(b_ovf),   32'(we_c && !wacc));
        end
        b_we = L; b_re = L;
        tick();
        chk("b hold valid", 32'(b_rvld),  32'(0));
        chk("b hold data",  32'(b_rdata), 32'(last_rd));

        // ---------------- mid-frame async reset ----------------
        a_we = H; a_wd = 8'h5A; a_wl = H; tick();
        a_wd = 8'h5B; a_wl = L;           tick();
        a_wd = 8'h5C;                     tick();
        a_we = L;
        chk("mid count", 32'(a_count), 32'(1));
        #2 rst_n = 1'b0;
        #1;
        chk("async count", 32'(a_count), 32'(0));
        chk("async empty", 32'(a_empty), 32'(1));
        chk("async valid", 32'(a_rvld),  32'(0));
        chk("async data",  32'(a_rdata), 32'(0));
        chk("async full",  32'(a_full),  32'(0));
        chk("async b valid", 32'(b_rvld),  32'(0));
        chk("async b data",  32'(b_rdata), 32'(0));
        chk("async b count", 32'(b_count), 32'(0));
        tick();
        rst_n = 1'b1;
        tick();
        a_re = H;
        tick();
        a_re = L;
        chk("post-rst udf",   32'(a_udf),   32'(1));
        chk("post-rst empty", 32'(a_empty), 32'(1));
        chk("post-rst count", 32'(a_count), 32'(0));
        tick();
        chk("post-rst udf idle",  32'(a_udf),   32'(0));
        chk("post-rst empty idle", 32'(a_empty), 32'(1));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
